// File: rtl/calc_seq_pkg.sv
// -----------------------------------------------------------------------------
// calc_seq_pkg
// Shared types for the calculator command sequencer:
//   - calc_status_e : calculator Status encoding (what the calculator reports)
//   - OP_*          : 2-bit calculator opcodes
//   - calc_vec_t    : one program vector {a, b, op [, exp_res, exp_flags]}
//   - seq_state_e   : sequencer FSM states (exposed on dbg_state)
//   - status_after  : Status the calculator reports once a field is accepted
// Optional feature macro: CALC_SEQ_SELFCHECK_EN adds expected result/flags
// fields to calc_vec_t.
// -----------------------------------------------------------------------------
package calc_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_A   = 3'd0,
    WAIT_B   = 3'd1,
    WAIT_OP  = 3'd2,
    SHOW_RES = 3'd3
  } calc_status_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
`ifdef CALC_SEQ_SELFCHECK_EN
    logic [15:0] exp_res;
    logic [4:0]  exp_flags;
`endif
  } calc_vec_t;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_SETUP     = 4'd2,
    S_PULSE     = 4'd3,
    S_GAP       = 4'd4,
    S_CHK       = 4'd5,
    S_WAIT_RES  = 4'd6,
    S_CAPTURE   = 4'd7,
    S_ACK_SETUP = 4'd8,
    S_ACK_PULSE = 4'd9,
    S_ACK_GAP   = 4'd10,
    S_ACK_CHK   = 4'd11,
    S_FIN       = 4'd12,
    S_ERR       = 4'd13
  } seq_state_e;

  // Field 0 (A) moves the calculator WAIT_A -> WAIT_B, field 1 (B)
  // WAIT_B -> WAIT_OP, field 2 (op) WAIT_OP -> SHOW_RES.
  function automatic logic [2:0] status_after(input logic [1:0] fld);
    return {1'b0, fld} + 3'd1;
  endfunction

endpackage

// File: rtl/calc_vector_rom.sv
// -----------------------------------------------------------------------------
// calc_vector_rom
// Combinational program ROM for the sequencer. Unused addresses read as zero.
// Ports:
//   vec_idx  in   4   vector address
//   vec      out  calc_vec_t  operand A, operand B, opcode
//                             (+ expected result/flags with CALC_SEQ_SELFCHECK_EN)
// Optional feature macro: CALC_SEQ_SELFCHECK_EN.
// Flag layout used for expected values: [0] zero, [1] carry/borrow,
// [2] negative, [3] signed overflow, [4] reserved (0).
// -----------------------------------------------------------------------------
module calc_vector_rom
  import calc_seq_pkg::*;
(
  input  logic [3:0] vec_idx,
  output calc_vec_t  vec
);

  always_comb begin
    vec = '0;
    case (vec_idx)
`ifdef CALC_SEQ_SELFCHECK_EN
      4'd0: vec = '{a: 16'h003F, b: 16'h0012, op: OP_ADD, exp_res: 16'h0051, exp_flags: 5'b00000};
      4'd1: vec = '{a: 16'h002A, b: 16'h007B, op: OP_ADD, exp_res: 16'h00A5, exp_flags: 5'b00000};
      4'd2: vec = '{a: 16'hFFFF, b: 16'h0001, op: OP_ADD, exp_res: 16'h0000, exp_flags: 5'b00011};
      4'd3: vec = '{a: 16'h0005, b: 16'h0003, op: OP_SUB, exp_res: 16'h0002, exp_flags: 5'b00000};
`else
      4'd0: vec = '{a: 16'h003F, b: 16'h0012, op: OP_ADD};
      4'd1: vec = '{a: 16'h002A, b: 16'h007B, op: OP_ADD};
      4'd2: vec = '{a: 16'hFFFF, b: 16'h0001, op: OP_ADD};
      4'd3: vec = '{a: 16'h0005, b: 16'h0003, op: OP_SUB};
`endif
      default: vec = '0;
    endcase
  end

endmodule

// File: rtl/calc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// calc_cmd_sequencer
// On-board self-test initiator for the calculator's Enter/DataIn entry
// protocol. Replays the vectors of calc_vector_rom: for each vector it enters
// A, B and the opcode, waits for the result, captures ToDisplay/Flags and then
// acknowledges with a fourth pulse (DataIn=0) that returns the calculator to
// WAIT_A.
//
// Entry handshake (the only handshake of this block): the sequencer presents
// a field on DataIn for one cycle with Enter low, raises Enter for ENTER_HOLD
// cycles with DataIn held, drops Enter for ENTER_GAP cycles with DataIn still
// held, and only then treats the field as accepted once Status shows the next
// calculator state. A Status that does not move within TIMEOUT+1 cycles of
// starting to wait ends the run in ERR.
//
// Parameters: N_VEC (1..16), ENTER_HOLD (>=1), ENTER_GAP (>=1), TIMEOUT.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle pulse, (re)starts the run from vector 0
//   Enter, DataIn       entry strobe and field value to the calculator
//   ToDisplay, Flags    calculator result and flags
//   Status              calculator state (calc_status_e)
//   res_value/res_flags last captured result; res_valid pulses on update
//   vec_idx             vector in progress / last completed
//   busy, done, error   run status (done/error hold until the next start)
//   dbg_state           current FSM state (seq_state_e)
//   mismatch            (CALC_SEQ_SELFCHECK_EN only) sticky result mismatch
// Optional feature macro: CALC_SEQ_SELFCHECK_EN.
// -----------------------------------------------------------------------------
module calc_cmd_sequencer
  import calc_seq_pkg::*;
#(
  parameter int N_VEC      = 4,
  parameter int ENTER_HOLD = 3,
  parameter int ENTER_GAP  = 3,
  parameter int TIMEOUT    = 255
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        Enter,
  output logic [15:0] DataIn,
  input  logic [15:0] ToDisplay,
  input  logic [4:0]  Flags,
  input  logic [2:0]  Status,
  output logic [15:0] res_value,
  output logic [4:0]  res_flags,
  output logic        res_valid,
  output logic [3:0]  vec_idx,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  dbg_state
`ifdef CALC_SEQ_SELFCHECK_EN
  ,
  output logic        mismatch
`endif
);

  // Timeout counter holds 0..TIMEOUT; phase counter holds 0..max(HOLD,GAP)-1.
  localparam int TW       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int PH_MAX   = (ENTER_HOLD > ENTER_GAP) ? ENTER_HOLD : ENTER_GAP;
  localparam int PW       = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT);
  localparam logic [PW-1:0] HOLD_LAST = PW'(ENTER_HOLD - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(ENTER_GAP - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(N_VEC - 1);

  seq_state_e      state, state_nxt;
  logic [3:0]      idx;
  calc_vec_t       cur;
  calc_vec_t       rom_vec;
  logic [1:0]      fld;
  logic [PW-1:0]   ph;
  logic [TW-1:0]   tmr;
  logic            res_seen;
  logic [15:0]     fld_data;
  logic            in_wait;
  logic            in_phase;

  calc_vector_rom u_rom (
    .vec_idx (idx),
    .vec     (rom_vec)
  );

  // Field currently being entered: A, B, then the opcode zero-extended.
  always_comb begin
    fld_data = 16'h0000;
    case (fld)
      2'd0:    fld_data = cur.a;
      2'd1:    fld_data = cur.b;
      default: fld_data = {14'h0000, cur.op};
    endcase
  end

  assign in_wait  = (state == S_CHK) || (state == S_WAIT_RES) || (state == S_ACK_CHK);
  assign in_phase = (state == S_PULSE) || (state == S_GAP) ||
                    (state == S_ACK_PULSE) || (state == S_ACK_GAP);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_FIN, S_ERR: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD:  state_nxt = S_SETUP;
      S_SETUP: state_nxt = S_PULSE;
      S_PULSE: begin
        if (ph == HOLD_LAST) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (ph == GAP_LAST) state_nxt = S_CHK;
      end
      S_CHK: begin
        if (Status == status_after(fld))
          state_nxt = (fld == 2'd2) ? S_WAIT_RES : S_SETUP;
        else if (tmr == TMO_LAST)
          state_nxt = S_ERR;
      end
      S_WAIT_RES: begin
        // SHOW_RES must be seen once, then one more cycle lets the result
        // settle before it is latched.
        if (res_seen)
          state_nxt = S_CAPTURE;
        else if ((Status != 3'(SHOW_RES)) && (tmr == TMO_LAST))
          state_nxt = S_ERR;
      end
      S_CAPTURE:   state_nxt = S_ACK_SETUP;
      S_ACK_SETUP: state_nxt = S_ACK_PULSE;
      S_ACK_PULSE: begin
        if (ph == HOLD_LAST) state_nxt = S_ACK_GAP;
      end
      S_ACK_GAP: begin
        if (ph == GAP_LAST) state_nxt = S_ACK_CHK;
      end
      S_ACK_CHK: begin
        if (Status == 3'(WAIT_A))
          state_nxt = (idx == LAST_IDX) ? S_FIN : S_LOAD;
        else if (tmr == TMO_LAST)
          state_nxt = S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      cur       <= '0;
      fld       <= 2'd0;
      ph        <= '0;
      tmr       <= '0;
      res_seen  <= 1'b0;
      res_value <= 16'h0000;
      res_flags <= 5'b00000;
`ifdef CALC_SEQ_SELFCHECK_EN
      mismatch  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      // Phase and timeout counters restart on every state change, so each
      // pulse, gap and wait is timed from its own entry.
      if (state_nxt != state)
        ph <= '0;
      else if (in_phase)
        ph <= ph + PW'(1);

      if (state_nxt != state)
        tmr <= '0;
      else if (in_wait)
        tmr <= tmr + TW'(1);

      if (state != S_WAIT_RES)
        res_seen <= 1'b0;
      else if (Status == 3'(SHOW_RES))
        res_seen <= 1'b1;

      case (state)
        S_IDLE, S_FIN, S_ERR: begin
          if (start) begin
            idx <= 4'd0;
`ifdef CALC_SEQ_SELFCHECK_EN
            mismatch <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          cur <= rom_vec;
          fld <= 2'd0;
        end
        S_CHK: begin
          if (state_nxt == S_SETUP) fld <= fld + 2'd1;
        end
        S_WAIT_RES: begin
          // Latch on the way into CAPTURE so res_value/res_flags already
          // hold the new result while res_valid is high.
          if (state_nxt == S_CAPTURE) begin
            res_value <= ToDisplay;
            res_flags <= Flags;
`ifdef CALC_SEQ_SELFCHECK_EN
            if ((ToDisplay != cur.exp_res) || (Flags != cur.exp_flags))
              mismatch <= 1'b1;
`endif
          end
        end
        S_ACK_CHK: begin
          if (state_nxt == S_LOAD) idx <= idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    Enter     = 1'b0;
    DataIn    = 16'h0000;
    busy      = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    res_valid = 1'b0;
    case (state)
      S_IDLE:                 busy = 1'b0;
      S_FIN:  begin           busy = 1'b0; done  = 1'b1; end
      S_ERR:  begin           busy = 1'b0; error = 1'b1; end
      S_SETUP, S_GAP, S_CHK:  DataIn = fld_data;
      S_PULSE: begin
        Enter  = 1'b1;
        DataIn = fld_data;
      end
      S_ACK_PULSE:            Enter = 1'b1;
      S_CAPTURE:              res_valid = 1'b1;
      default: ;
    endcase
  end

  assign vec_idx   = idx;
  assign dbg_state = state;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_cmd_sequencer
// Bench for calc_cmd_sequencer. A behavioural calculator answers each Enter
// rising edge after a random latency; a monitor checks pulse shape and the
// DataIn sequence against an expected queue; a vector table holds the
// results the calculator is expected to produce. Define CALC_SEQ_SELFCHECK_EN
// on both RTL and bench to exercise the mismatch output.
// -----------------------------------------------------------------------------
module tb_calc_cmd_sequencer;
  import calc_seq_pkg::*;

  localparam int N_VEC = 4;
  localparam int HOLD  = 3;
  localparam int GAP   = 3;
  localparam int TMO   = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        Enter;
  logic [15:0] DataIn;
  logic [15:0] ToDisplay;
  logic [4:0]  Flags;
  logic [2:0]  Status;
  logic [15:0] res_value;
  logic [4:0]  res_flags;
  logic        res_valid;
  logic [3:0]  vec_idx;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  dbg_state;
`ifdef CALC_SEQ_SELFCHECK_EN
  logic        mismatch;
`endif

  // ---------------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  calc_cmd_sequencer #(
    .N_VEC      (N_VEC),
    .ENTER_HOLD (HOLD),
    .ENTER_GAP  (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .Enter     (Enter),
    .DataIn    (DataIn),
    .ToDisplay (ToDisplay),
    .Flags     (Flags),
    .Status    (Status),
    .res_value (res_value),
    .res_flags (res_flags),
    .res_valid (res_valid),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .dbg_state (dbg_state)
`ifdef CALC_SEQ_SELFCHECK_EN
    ,
    .mismatch  (mismatch)
`endif
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] res;
    logic [4:0]  flg;
  } vec_rec_t;

  vec_rec_t tbl [N_VEC];

  // ---------------------------------------------------------------- calculator model
  // Flags: [0] zero, [1] carry/borrow, [2] negative, [3] signed overflow.
  function automatic logic [20:0] calc_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
    logic [16:0] w;
    logic [15:0] r;
    logic        c;
    logic        v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0];
        c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return {1'b0, v, r[15], c, (r == 16'h0000), r};
  endfunction

  int          calc_st = 0;
  int          pend_cnt = 0;
  int          pend_st = 0;
  logic [15:0] pend_disp = 16'h0;
  logic [4:0]  pend_flg = 5'h0;
  logic [15:0] ra = 16'h0;
  logic [15:0] rb = 16'h0;
  logic        prev_en = 1'b0;
  bit          stall_b = 1'b0;
  bit          corrupt_v0 = 1'b0;

  initial begin
    Status    = 3'd0;
    ToDisplay = 16'h0;
    Flags     = 5'h0;
    forever begin
      @(negedge clk);
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          calc_st   = pend_st;
          ToDisplay = pend_disp;
          Flags     = pend_flg;
        end
      end
      if (Enter && !prev_en && pend_cnt == 0) begin
        case (calc_st)
          0: begin
            ra = DataIn; pend_st = 1; pend_disp = DataIn; pend_flg = 5'h0;
            pend_cnt = int'($urandom_range(1, 4));
          end
          1: begin
            rb = DataIn;
            if (!stall_b) begin
              pend_st = 2; pend_disp = DataIn; pend_flg = 5'h0;
              pend_cnt = int'($urandom_range(1, 4));
            end
          end
          2: begin
            {pend_flg, pend_disp} = calc_fn(ra, rb, DataIn[1:0]);
            if (corrupt_v0 && ra == 16'h003F && rb == 16'h0012) pend_disp = 16'h0050;
            pend_st = 3;
            pend_cnt = int'($urandom_range(1, 4));
          end
          default: begin
            pend_st = 0; pend_disp = 16'h0; pend_flg = 5'h0;
            pend_cnt = int'($urandom_range(1, 4));
          end
        endcase
      end
      prev_en = Enter;
      Status  = 3'(calc_st);
    end
  end

  task automatic model_reset();
    calc_st  = 0;
    pend_cnt = 0;
  endtask

  // ---------------------------------------------------------------- monitor / scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] got_res[$];
  logic [4:0]  got_flg[$];
  int          pulses = 0;
  int          hi_len = 0;
  int          low_len = 1000;
  int          last_fall = 0;
  logic        was_hi = 1'b0;
  logic        prev_rv = 1'b0;
  logic [15:0] prev_din = 16'h0;

  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        was_hi  = 1'b0;
        hi_len  = 0;
        low_len = 1000;
        prev_rv = 1'b0;
      end else begin
        if (Enter) begin
          if (!was_hi) begin
            pulses++;
            check("enter_setup_stable", DataIn, prev_din);
            check("enter_gap_min", (low_len >= GAP), 1);
            check("datain_pending", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("datain_seq", DataIn, e);
            end
            hi_len = 1;
          end else begin
            hi_len++;
            check("datain_hold", DataIn, prev_din);
          end
        end else begin
          if (was_hi) begin
            check("enter_hold_len", hi_len, HOLD);
            low_len   = 1;
            last_fall = cyc;
          end else begin
            low_len++;
          end
        end
        if (res_valid) begin
          check("res_valid_one_cycle", prev_rv, 0);
          got_res.push_back(res_value);
          got_flg.push_back(res_flags);
        end
        was_hi  = Enter;
        prev_rv = res_valid;
      end
      prev_din = DataIn;
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_clear_on_start", done, 0);
    check("error_clear_on_start", error, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_vectors(input bit corrupt);
    int          p0;
    logic        prev_busy;
    logic [15:0] er;
    for (int i = 0; i < N_VEC; i++) begin
      exp_q.push_back(tbl[i].a);
      exp_q.push_back(tbl[i].b);
      exp_q.push_back({14'h0, tbl[i].op});
      exp_q.push_back(16'h0000);
    end
    got_res.delete();
    got_flg.delete();
    p0 = pulses;
    pulse_start();
    prev_busy = busy;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done || error) break;
      prev_busy = busy;
    end
    check("run_finished", (done || error), 1);
    check("run_done", done, 1);
    check("run_error", error, 0);
    check("busy_low_with_done", busy, 0);
    check("busy_high_before_done", prev_busy, 1);
    check("vec_idx_final", vec_idx, N_VEC - 1);
    check("datain_final", DataIn, 0);
    check("enter_final", Enter, 0);
    check("enter_pulse_count", pulses - p0, 4 * N_VEC);
    check("datain_all_sent", exp_q.size(), 0);
    check("result_count", got_res.size(), N_VEC);
    for (int i = 0; i < N_VEC; i++) begin
      er = (corrupt && i == 0) ? 16'h0050 : tbl[i].res;
      if (i < got_res.size()) begin
        check($sformatf("res_value_v%0d", i), got_res[i], er);
        check($sformatf("res_flags_v%0d", i), got_flg[i], tbl[i].flg);
      end
    end
    check("res_value_port_last", res_value, tbl[N_VEC-1].res);
`ifdef CALC_SEQ_SELFCHECK_EN
    check("mismatch_flag", mismatch, corrupt);
`endif
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- test
  initial begin
    int p0;
    int err_cyc;
    int hi_cnt;

    tbl[0] = '{a: 16'h003F, b: 16'h0012, op: 2'd0, res: 16'h0051, flg: 5'b00000};
    tbl[1] = '{a: 16'h002A, b: 16'h007B, op: 2'd0, res: 16'h00A5, flg: 5'b00000};
    tbl[2] = '{a: 16'hFFFF, b: 16'h0001, op: 2'd0, res: 16'h0000, flg: 5'b00011};
    tbl[3] = '{a: 16'h0005, b: 16'h0003, op: 2'd1, res: 16'h0002, flg: 5'b00000};

    reset = 1'b1;
    start = 1'b0;

    // Reset held three cycles with no start: everything quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_enter", Enter, 0);
      check("rst_datain", DataIn, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
    end
    check("rst_state_idle", dbg_state, 4'(S_IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("idle_res_valid", res_valid, 0);
    check("idle_res_value", res_value, 0);
    check("idle_vec_idx", vec_idx, 0);
    check("idle_busy", busy, 0);

    // Full runs with random calculator latency; later runs restart from done.
    for (int r = 0; r < 3; r++) begin
      idle_cycles(int'($urandom_range(0, 5)));
      run_vectors(1'b0);
    end

    // start while busy is ignored: the run still finishes with 16 pulses.
    idle_cycles(2);
    for (int i = 0; i < N_VEC; i++) begin
      exp_q.push_back(tbl[i].a);
      exp_q.push_back(tbl[i].b);
      exp_q.push_back({14'h0, tbl[i].op});
      exp_q.push_back(16'h0000);
    end
    p0 = pulses;
    pulse_start();
    idle_cycles(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done || error) break;
    end
    check("busy_start_ignored_done", done, 1);
    check("busy_start_ignored_pulses", pulses - p0, 4 * N_VEC);
    exp_q.delete();

    // Calculator stalls at WAIT_B after the B pulse: timeout into ERR.
    stall_b = 1'b1;
    exp_q.push_back(tbl[0].a);
    exp_q.push_back(tbl[0].b);
    p0 = pulses;
    pulse_start();
    err_cyc = -1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (error) begin
        err_cyc = cyc;
        break;
      end
    end
    check("stall_error", error, 1);
    check("stall_timeout_cycles", err_cyc - last_fall, GAP + TMO + 1);
    check("stall_vec_idx", vec_idx, 0);
    check("stall_busy", busy, 0);
    check("stall_done", done, 0);
    check("stall_pulses", pulses - p0, 2);
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (Enter) hi_cnt++;
    end
    check("stall_enter_quiet", hi_cnt, 0);
    check("stall_datain_zero", DataIn, 0);
    check("stall_error_sticky", error, 1);
    stall_b = 1'b0;
    model_reset();
    exp_q.delete();
    idle_cycles(3);

    // start from ERR clears error and runs from vector 0.
    run_vectors(1'b0);

    // Reset during the Enter pulse of vector 1.
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(tbl[i].a);
      if (i == 0) begin
        exp_q.push_back(tbl[i].b);
        exp_q.push_back({14'h0, tbl[i].op});
        exp_q.push_back(16'h0000);
      end
    end
    p0 = pulses;
    pulse_start();
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (Enter && (pulses - p0) >= 5) break;
    end
    check("midrun_reached_v1_pulse", vec_idx, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_enter", Enter, 0);
    check("midrst_datain", DataIn, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_value", res_value, 0);
    check("midrst_res_flags", res_flags, 0);
    check("midrst_vec_idx", vec_idx, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(2);
    run_vectors(1'b0);

`ifdef CALC_SEQ_SELFCHECK_EN
    // Calculator returns a wrong result for vector 0: flagged, run completes.
    corrupt_v0 = 1'b1;
    run_vectors(1'b1);
    corrupt_v0 = 1'b0;
    run_vectors(1'b0);
`endif

    idle_cycles(3);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
